// File: rtl/fft_pkg.sv
// Shared FFT1024 pipeline definitions: frame geometry defaults, complex sample
// layout, per-bank buffer state and the bit-reversal helper.
package fft_pkg;

    localparam int unsigned FFT_N_LOG2     = 10;
    localparam int unsigned FFT_DATA_WIDTH = 17;

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] img;
    } cplx_t;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } bank_state_t;

    // Reverses the low 'width' bits of 'value'; upper bits return zero.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < width && i < 32; i++) begin
            r[i] = value[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_dpram_sync.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// The address MSB selects the ping-pong bank.
module fft_dpram_sync #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 34
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong unscrambler: bit-reversed input frames re-emitted in natural bin order.
// Define FFT_REORDER_ERR_CNT_EN to add the saturating aborted-frame counter port err_cnt.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned N_LOG2     = FFT_N_LOG2,
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_img,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sof,
    output logic                  out_eof,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_img,
    output logic                  frame_err
`ifdef FFT_REORDER_ERR_CNT_EN
    ,
    output logic [7:0]            err_cnt
`endif
);

    localparam int unsigned N  = 1 << N_LOG2;
    localparam int unsigned AW = N_LOG2 + 1;

    typedef logic [N_LOG2-1:0] idx_t;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] img;
    } sample_t;

    localparam idx_t LAST = idx_t'(N - 1);

    bank_state_t bank_state [2];
    bank_state_t bank_next  [2];
    logic        wr_bank;
    logic        rd_bank;
    idx_t        wr_cnt;
    idx_t        rd_cnt;

    // Write side
    logic          in_fire;
    logic          filling;
    logic          wr_en;
    logic          wr_last;
    logic          abort;
    idx_t          wr_idx;
    logic [AW-1:0] wr_addr;

    assign in_ready = (bank_state[wr_bank] == EMPTY) || (bank_state[wr_bank] == FILLING);
    assign in_fire  = in_valid && in_ready;
    assign filling  = (bank_state[wr_bank] == FILLING);
    assign wr_en    = in_fire && (in_sof || filling);
    assign wr_idx   = in_sof ? '0 : wr_cnt;
    assign wr_last  = wr_en && (wr_idx == LAST);
    assign abort    = in_fire && in_sof && filling;
    assign wr_addr  = {wr_bank, idx_t'(bitrev(32'(wr_idx), N_LOG2))};

    // Read side: at most two samples in flight between RAM output, skid slot and output register
    logic          pop;
    logic [1:0]    occ;
    logic          space;
    logic          rd_active;
    logic          rd_issue;
    logic          rd_last;
    logic [AW-1:0] rd_addr;
    sample_t       ram_q;

    logic          pend;
    logic          pend_sof;
    logic          pend_eof;
    logic          skid_valid;
    logic          skid_sof;
    logic          skid_eof;
    sample_t       skid_data;
    logic          load;

    assign pop       = out_valid && out_ready;
    assign occ       = 2'(out_valid) + 2'(skid_valid) + 2'(pend);
    assign space     = (occ - 2'(pop)) < 2'd2;
    assign rd_active = (bank_state[rd_bank] == FULL) || (bank_state[rd_bank] == DRAINING);
    assign rd_issue  = rd_active && space;
    assign rd_last   = rd_issue && (rd_cnt == LAST);
    assign rd_addr   = {rd_bank, rd_cnt};
    assign load      = !out_valid || out_ready;

    fft_dpram_sync #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (2 * DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data ({in_re, in_img}),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // The bank is released once its last RAM read is issued: the remaining samples
    // already live in the output pipeline, so the writer may reuse it next clock.
    always_comb begin
        bank_next = bank_state;
        if (wr_en) begin
            bank_next[wr_bank] = wr_last ? FULL : FILLING;
        end
        if (rd_issue) begin
            bank_next[rd_bank] = rd_last ? EMPTY : DRAINING;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state <= '{EMPTY, EMPTY};
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            pend       <= 1'b0;
            pend_sof   <= 1'b0;
            pend_eof   <= 1'b0;
            skid_valid <= 1'b0;
            skid_sof   <= 1'b0;
            skid_eof   <= 1'b0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_re     <= '0;
            out_img    <= '0;
        end else begin
            bank_state <= bank_next;

            if (wr_en) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_idx + idx_t'(1);
                end
            end

            if (rd_issue) begin
                if (rd_last) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + idx_t'(1);
                end
            end

            pend     <= rd_issue;
            pend_sof <= rd_issue && (rd_cnt == '0);
            pend_eof <= rd_last;

            if (load) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_sof    <= skid_sof;
                    out_eof    <= skid_eof;
                    out_re     <= skid_data.re;
                    out_img    <= skid_data.img;
                    skid_valid <= pend;
                    skid_sof   <= pend_sof;
                    skid_eof   <= pend_eof;
                    skid_data  <= ram_q;
                end else begin
                    out_valid <= pend;
                    out_sof   <= pend_sof;
                    out_eof   <= pend_eof;
                    if (pend) begin
                        out_re  <= ram_q.re;
                        out_img <= ram_q.img;
                    end
                end
            end else if (pend) begin
                skid_valid <= 1'b1;
                skid_sof   <= pend_sof;
                skid_eof   <= pend_eof;
                skid_data  <= ram_q;
            end
        end
    end

`ifdef FFT_REORDER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (abort && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign frame_err = (err_cnt != '0);
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else if (abort) begin
            frame_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: small (N=8) instance for ordering, stall,
// abort and reset cases; full-size (N=1024) instance for back-to-back throughput.
module tb_fft_bitrev_reorder;

    logic clk;
    logic rst;

    // N = 8 instance
    logic        in_valid, in_ready, in_sof;
    logic [16:0] in_re, in_img;
    logic        out_valid, out_ready, out_sof, out_eof;
    logic [16:0] out_re, out_img;
    logic        frame_err;
`ifdef FFT_REORDER_ERR_CNT_EN
    logic [7:0]  err_cnt;
    logic [7:0]  b_err_cnt;
`endif

    // N = 1024 instance
    logic        b_in_valid, b_in_ready, b_in_sof;
    logic [16:0] b_in_re, b_in_img;
    logic        b_out_valid, b_out_ready, b_out_sof, b_out_eof;
    logic [16:0] b_out_re, b_out_img;
    logic        b_frame_err;

    fft_bitrev_reorder #(.N_LOG2(3), .DATA_WIDTH(17)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_re(in_re), .in_img(in_img),
        .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof), .out_eof(out_eof),
        .out_re(out_re), .out_img(out_img), .frame_err(frame_err)
`ifdef FFT_REORDER_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    fft_bitrev_reorder #(.N_LOG2(10), .DATA_WIDTH(17)) dut_big (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
        .in_re(b_in_re), .in_img(b_in_img),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sof(b_out_sof), .out_eof(b_out_eof),
        .out_re(b_out_re), .out_img(b_out_img), .frame_err(b_frame_err)
`ifdef FFT_REORDER_ERR_CNT_EN
        , .err_cnt(b_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [16:0] re;
        logic [16:0] img;
    } obs_t;

    int    vectors     = 0;
    int    miscompares = 0;
    obs_t  exp_q[$];
    logic  held        = 1'b0;
    obs_t  held_val;
    bit    rdy_mode    = 1'b0;
    int    rdy_idx     = 0;
    logic [15:0] rdy_pat = 16'b1001_1010_0110_0101;
    logic  saw_block   = 1'b0;
    int    brt [8]     = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic obs_t cur_out();
        return {out_sof, out_eof, out_re, out_img};
    endfunction

    function automatic logic [16:0] rev10(input int v);
        logic [9:0] a;
        logic [9:0] r;
        a = 10'(v);
        for (int i = 0; i < 10; i++) r[i] = a[9-i];
        return 17'(r);
    endfunction

    // One clock of the small instance: check outputs seen now, then advance past the edge.
    task automatic cycle(output bit acc);
        out_ready = rdy_mode ? rdy_pat[rdy_idx % 16] : 1'b1;
        rdy_idx++;
        if (held) check("stall_hold", cur_out(), held_val);
        if (in_valid && !in_ready) saw_block = 1'b1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
            else check("out_bin", cur_out(), exp_q.pop_front());
        end
        held     = out_valid && !out_ready;
        held_val = cur_out();
        acc      = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [16:0] re, input logic [16:0] img, input logic sof);
        bit acc;
        int t;
        in_valid = 1'b1;
        in_sof   = sof;
        in_re    = re;
        in_img   = img;
        acc      = 1'b0;
        t        = 0;
        while (!acc && t < 200) begin
            cycle(acc);
            t++;
        end
        if (!acc) check("in_accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    // ext=1: alternating 17-bit extremes; otherwise position k carries base+bitrev(k).
    task automatic send_frame(input int base, input bit ext, input bit push_exp, input int n);
        logic [16:0] re, img;
        if (push_exp) begin
            for (int b = 0; b < 8; b++) begin
                if (ext) begin
                    re  = (b < 4) ? 17'h10000 : 17'h0FFFF;
                    img = 17'h1FFFF;
                end else begin
                    re  = 17'(base + b);
                    img = 17'(-(base + b));
                end
                exp_q.push_back({b == 0, b == 7, re, img});
            end
        end
        for (int k = 0; k < n; k++) begin
            if (ext) begin
                re  = (k % 2 == 0) ? 17'h10000 : 17'h0FFFF;
                img = 17'h1FFFF;
            end else begin
                re  = 17'(base + brt[k]);
                img = 17'(-(base + brt[k]));
            end
            send_sample(re, img, k == 0);
        end
    endtask

    task automatic drain();
        bit acc;
        int t;
        in_valid = 1'b0;
        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            cycle(acc);
            t++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (4) cycle(acc);
    endtask

    initial begin
        bit acc;
        int t;
        int i_big;
        int o_big;
        int big_blocked;
        obs_t bexp;

        rst = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0; in_re = '0; in_img = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_re = '0; b_in_img = '0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sof", 64'(out_sof), 64'd0);
        check("rst_out_eof", 64'(out_eof), 64'd0);
        check("rst_out_data", {out_re, out_img}, 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Samples before the first sof are dropped with in_ready held high
        in_valid = 1'b1; in_sof = 1'b0; in_re = 17'h01234; in_img = 17'h00055;
        check("presof_ready", 64'(in_ready), 64'd1);
        cycle(acc);
        cycle(acc);
        check("presof_ready_hold", 64'(in_ready), 64'd1);
        in_valid = 1'b0;

        // Test 1: one frame, 0,4,2,6,1,5,3,7 in -> 0..7 out, latency 2 clk
        send_frame(0, 1'b0, 1'b1, 8);
        check("lat_edge1_valid", 64'(out_valid), 64'd0);
        cycle(acc);
        check("lat_edge2_valid", 64'(out_valid), 64'd0);
        cycle(acc);
        check("lat_first_bin", {out_valid, out_sof, out_re}, {1'b1, 1'b1, 17'd0});
        drain();

        // Test 3: out_ready stalls; three frames back to back
        rdy_mode  = 1'b1;
        saw_block = 1'b0;
        send_frame(100, 1'b0, 1'b1, 8);
        send_frame(200, 1'b0, 1'b1, 8);
        send_frame(300, 1'b0, 1'b1, 8);
        drain();
        rdy_mode = 1'b0;
        check("stall_in_ready_low", 64'(saw_block), 64'd1);

        // Test 4: sof reasserted at wr_cnt=5 aborts the partial frame
        send_frame(400, 1'b0, 1'b0, 5);
        check("abort_err_clear_before", 64'(frame_err), 64'd0);
        send_frame(500, 1'b0, 1'b1, 8);
        drain();
        check("abort_frame_err", 64'(frame_err), 64'd1);
`ifdef FFT_REORDER_ERR_CNT_EN
        check("abort_err_cnt", 64'(err_cnt), 64'd1);
`endif

        // Test 5: reset while bin 3 is presented
        send_frame(600, 1'b0, 1'b1, 8);
        t = 0;
        while (!(out_valid && out_re == 17'd603) && t < 50) begin
            cycle(acc);
            t++;
        end
        check("pre_rst_bin3", {out_valid, out_re}, {1'b1, 17'd603});
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        held = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_flags", {out_sof, out_eof}, 64'd0);
        check("midrst_frame_err", 64'(frame_err), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (6) cycle(acc);
        send_frame(700, 1'b0, 1'b1, 8);
        drain();

        // Test 6: 17-bit extremes pass bit-exact
        send_frame(0, 1'b1, 1'b1, 8);
        drain();

        // Test 2: N=1024, four continuous frames at one sample per clock
        i_big = 0;
        o_big = 0;
        big_blocked = 0;
        t = 0;
        while ((i_big < 4096 || o_big < 4096) && t < 6000) begin
            if (b_out_valid) begin
                bexp = {(o_big % 1024) == 0, (o_big % 1024) == 1023, 17'(o_big), 17'(-o_big)};
                check("big_bin", {b_out_sof, b_out_eof, b_out_re, b_out_img}, bexp);
                o_big++;
            end
            if (i_big < 4096) begin
                b_in_valid = 1'b1;
                b_in_sof   = (i_big % 1024) == 0;
                b_in_re    = rev10(i_big % 1024) + 17'(1024 * (i_big / 1024));
                b_in_img   = 17'(-(rev10(i_big % 1024) + 17'(1024 * (i_big / 1024))));
                if (b_in_ready) i_big++;
                else big_blocked++;
            end else begin
                b_in_valid = 1'b0;
                b_in_sof   = 1'b0;
            end
            @(posedge clk);
            #1;
            t++;
        end
        check("big_out_count", 64'(o_big), 64'd4096);
        check("big_in_ready_drops", 64'(big_blocked), 64'd0);
        check("big_frame_err", 64'(b_frame_err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
